// File: rtl/sram_arbiter_pkg.sv
// Shared types for the SRAM arbiter: FSM states, requester ports and
// the electrical levels of the active-low SRAM strobes.
package sram_arb_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_SETUP = 3'd1,
    WR_PULSE = 3'd2,
    WR_HOLD  = 3'd3,
    RD_ADDR  = 3'd4,
    RD_CAP   = 3'd5
  } state_t;

  typedef enum logic {
    PORT_WR = 1'b0,
    PORT_RD = 1'b1
  } port_t;

  localparam logic STROBE_IDLE   = 1'b1;
  localparam logic STROBE_ACTIVE = 1'b0;

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester-side bundle: recorder write port, player read port and busy flag.
// Handshake: a requester raises *_req with stable address/data and holds it until
// its completion pulse (o_wr_ack / o_rd_valid); a request still high on the cycle
// after that pulse is a new transaction.
interface sram_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
) ();
  logic              i_wr_req;
  logic [ADDR_W-1:0] i_wr_addr;
  logic [DATA_W-1:0] i_wr_data;
  logic              o_wr_ack;
  logic              i_rd_req;
  logic [ADDR_W-1:0] i_rd_addr;
  logic              o_rd_valid;
  logic [DATA_W-1:0] o_rd_data;
  logic              o_busy;

  modport slave (
    input  i_wr_req, i_wr_addr, i_wr_data, i_rd_req, i_rd_addr,
    output o_wr_ack, o_rd_valid, o_rd_data, o_busy
  );

  modport master (
    output i_wr_req, i_wr_addr, i_wr_data, i_rd_req, i_rd_addr,
    input  o_wr_ack, o_rd_valid, o_rd_data, o_busy
  );
endinterface

// File: rtl/sram_arbiter.sv
// Single-port SRAM sequencer shared by the recorder (write) and player (read).
// Every SRAM pin and handshake output is a flop decoded from the next state.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 16,
  parameter bit READ_FIRST = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  sram_arbiter_if.slave     req_if,
  output logic [ADDR_W-1:0] o_SRAM_ADDR,
  inout  wire  [DATA_W-1:0] io_SRAM_DQ,
  output logic              o_SRAM_WE_N,
  output logic              o_SRAM_OE_N,
  output logic              o_SRAM_CE_N,
  output logic              o_SRAM_LB_N,
  output logic              o_SRAM_UB_N,
  output state_t            o_dbg_state
);

  state_t            r_state, w_next_state;
  port_t             r_last_gnt, w_gnt_port;
  logic              w_grant;
  logic              w_ce_n, w_we_n, w_oe_n, w_dq_oe;

  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_dq_oe;
  logic              r_we_n, r_oe_n, r_ce_n, r_byte_n;
  logic              r_wr_ack, r_rd_valid, r_busy;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    w_gnt_port   = PORT_RD;
    case (r_state)
      IDLE: begin
        // On a tie, round-robin hands the bus to whichever port did not go last.
        if (req_if.i_wr_req && req_if.i_rd_req) begin
          w_grant    = 1'b1;
          w_gnt_port = (READ_FIRST || r_last_gnt == PORT_WR) ? PORT_RD : PORT_WR;
        end else if (req_if.i_rd_req) begin
          w_grant    = 1'b1;
          w_gnt_port = PORT_RD;
        end else if (req_if.i_wr_req) begin
          w_grant    = 1'b1;
          w_gnt_port = PORT_WR;
        end
        if (w_grant) w_next_state = (w_gnt_port == PORT_RD) ? RD_ADDR : WR_SETUP;
      end
      WR_SETUP: w_next_state = WR_PULSE;
      WR_PULSE: w_next_state = WR_HOLD;
      WR_HOLD:  w_next_state = IDLE;
      RD_ADDR:  w_next_state = RD_CAP;
      RD_CAP:   w_next_state = IDLE;
      default:  w_next_state = IDLE;
    endcase

    w_ce_n  = (w_next_state == IDLE) ? STROBE_IDLE : STROBE_ACTIVE;
    w_we_n  = (w_next_state == WR_PULSE) ? STROBE_ACTIVE : STROBE_IDLE;
    w_oe_n  = (w_next_state == RD_ADDR || w_next_state == RD_CAP) ? STROBE_ACTIVE : STROBE_IDLE;
    w_dq_oe = (w_next_state == WR_SETUP || w_next_state == WR_PULSE ||
               w_next_state == WR_HOLD);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_gnt <= PORT_WR;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rd_data  <= '0;
      r_dq_oe    <= 1'b0;
      r_we_n     <= STROBE_IDLE;
      r_oe_n     <= STROBE_IDLE;
      r_ce_n     <= STROBE_IDLE;
      r_byte_n   <= STROBE_IDLE;
      r_wr_ack   <= 1'b0;
      r_rd_valid <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      if (w_grant) begin
        r_last_gnt <= w_gnt_port;
        r_addr     <= (w_gnt_port == PORT_WR) ? req_if.i_wr_addr : req_if.i_rd_addr;
        if (w_gnt_port == PORT_WR) r_wdata <= req_if.i_wr_data;
      end
      // The SRAM has had a full RD_ADDR + RD_CAP window of OE low by this edge.
      if (r_state == RD_CAP) r_rd_data <= io_SRAM_DQ;
      r_rd_valid <= (r_state == RD_CAP);
      r_wr_ack   <= (w_next_state == WR_HOLD);
      r_dq_oe    <= w_dq_oe;
      r_we_n     <= w_we_n;
      r_oe_n     <= w_oe_n;
      r_ce_n     <= w_ce_n;
      r_byte_n   <= w_ce_n;
      r_busy     <= (w_next_state != IDLE);
    end
  end

  assign io_SRAM_DQ = r_dq_oe ? r_wdata : {DATA_W{1'bz}};

  assign o_SRAM_ADDR       = r_addr;
  assign o_SRAM_WE_N       = r_we_n;
  assign o_SRAM_OE_N       = r_oe_n;
  assign o_SRAM_CE_N       = r_ce_n;
  assign o_SRAM_LB_N       = r_byte_n;
  assign o_SRAM_UB_N       = r_byte_n;
  assign req_if.o_wr_ack   = r_wr_ack;
  assign req_if.o_rd_valid = r_rd_valid;
  assign req_if.o_rd_data  = r_rd_data;
  assign req_if.o_busy     = r_busy;
  assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: round-robin instance with a small SRAM model, plus a
// read-priority instance for the tie-break policy.
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- DUT 0: round-robin, with SRAM model ----------------
  sram_arbiter_if #(.ADDR_W(20), .DATA_W(16)) bus0 ();
  logic [19:0] sram0_addr;
  wire  [15:0] sram0_dq;
  logic        we0_n, oe0_n, ce0_n, lb0_n, ub0_n;
  state_t      st0;

  sram_arbiter #(.ADDR_W(20), .DATA_W(16), .READ_FIRST(1'b0)) dut0 (
    .i_clk(clk), .i_rst(rst), .req_if(bus0.slave),
    .o_SRAM_ADDR(sram0_addr), .io_SRAM_DQ(sram0_dq),
    .o_SRAM_WE_N(we0_n), .o_SRAM_OE_N(oe0_n), .o_SRAM_CE_N(ce0_n),
    .o_SRAM_LB_N(lb0_n), .o_SRAM_UB_N(ub0_n), .o_dbg_state(st0)
  );

  logic [15:0] mem [256];
  always @(posedge clk) if (!ce0_n && !we0_n) mem[sram0_addr[7:0]] <= sram0_dq;
  assign sram0_dq = (!ce0_n && !oe0_n) ? mem[sram0_addr[7:0]] : 16'bz;

  // ---------------- DUT 1: read-first ----------------
  sram_arbiter_if #(.ADDR_W(20), .DATA_W(16)) bus1 ();
  logic [19:0] sram1_addr;
  wire  [15:0] sram1_dq;
  logic        we1_n, oe1_n, ce1_n, lb1_n, ub1_n;
  state_t      st1;

  sram_arbiter #(.ADDR_W(20), .DATA_W(16), .READ_FIRST(1'b1)) dut1 (
    .i_clk(clk), .i_rst(rst), .req_if(bus1.slave),
    .o_SRAM_ADDR(sram1_addr), .io_SRAM_DQ(sram1_dq),
    .o_SRAM_WE_N(we1_n), .o_SRAM_OE_N(oe1_n), .o_SRAM_CE_N(ce1_n),
    .o_SRAM_LB_N(lb1_n), .o_SRAM_UB_N(ub1_n), .o_dbg_state(st1)
  );

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr_req;
    logic [19:0] wr_addr;
    logic [15:0] wr_data;
    logic        rd_req;
    logic [19:0] rd_addr;
    state_t      st;
    logic        we_n, oe_n, ce_n;
    logic [19:0] addr;
    logic        ack, valid, busy;
    logic        dq_chk;
    logic [15:0] dq;
    logic [15:0] rd_data;
  } vec_t;

  function automatic vec_t mk(input logic wr, input logic [19:0] wa, input logic [15:0] wd,
                              input logic rd, input logic [19:0] ra, input state_t st,
                              input logic we, input logic oe, input logic ce,
                              input logic [19:0] ad, input logic ak, input logic vl,
                              input logic bz, input logic dc, input logic [15:0] dq,
                              input logic [15:0] rdd);
    vec_t v;
    v.wr_req = wr; v.wr_addr = wa; v.wr_data = wd; v.rd_req = rd; v.rd_addr = ra;
    v.st = st; v.we_n = we; v.oe_n = oe; v.ce_n = ce; v.addr = ad;
    v.ack = ak; v.valid = vl; v.busy = bz; v.dq_chk = dc; v.dq = dq; v.rd_data = rdd;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    logic [3:0] gnt_pat;
    int         gnt_cnt;
    int         ack_cnt;
    int         rv_cnt;
    logic       overlap;
    logic       wr_seen;
    logic       found;

    bus0.i_wr_req = 0; bus0.i_wr_addr = '0; bus0.i_wr_data = '0;
    bus0.i_rd_req = 0; bus0.i_rd_addr = '0;
    bus1.i_wr_req = 0; bus1.i_wr_addr = '0; bus1.i_wr_data = '0;
    bus1.i_rd_req = 0; bus1.i_rd_addr = '0;

    //        wr wa        wd       rd ra        state     we oe ce addr      ak vl bz dc dq       rd_data
    vecs.push_back(mk(1, 20'h00010, 16'hA5A5, 0, 20'h0,     WR_SETUP, 1, 1, 0, 20'h00010, 0, 0, 1, 1, 16'hA5A5, 16'h0000));
    vecs.push_back(mk(1, 20'h003FF, 16'h1234, 0, 20'h0,     WR_PULSE, 0, 1, 0, 20'h00010, 0, 0, 1, 1, 16'hA5A5, 16'h0000));
    vecs.push_back(mk(1, 20'h003FF, 16'h1234, 0, 20'h0,     WR_HOLD,  1, 1, 0, 20'h00010, 1, 0, 1, 1, 16'hA5A5, 16'h0000));
    vecs.push_back(mk(0, 20'h0,     16'h0,    0, 20'h0,     IDLE,     1, 1, 1, 20'h00010, 0, 0, 0, 0, 16'h0,    16'h0000));
    vecs.push_back(mk(0, 20'h0,     16'h0,    1, 20'h00010, RD_ADDR,  1, 0, 0, 20'h00010, 0, 0, 1, 0, 16'h0,    16'h0000));
    vecs.push_back(mk(0, 20'h0,     16'h0,    1, 20'h00055, RD_CAP,   1, 0, 0, 20'h00010, 0, 0, 1, 0, 16'h0,    16'h0000));
    vecs.push_back(mk(0, 20'h0,     16'h0,    0, 20'h0,     IDLE,     1, 1, 1, 20'h00010, 0, 1, 0, 0, 16'h0,    16'hA5A5));
    vecs.push_back(mk(0, 20'h0,     16'h0,    0, 20'h0,     IDLE,     1, 1, 1, 20'h00010, 0, 0, 0, 0, 16'h0,    16'hA5A5));
    // top address, request dropped right after grant
    vecs.push_back(mk(1, 20'hFFFFF, 16'h5A5A, 0, 20'h0,     WR_SETUP, 1, 1, 0, 20'hFFFFF, 0, 0, 1, 1, 16'h5A5A, 16'hA5A5));
    vecs.push_back(mk(0, 20'h0,     16'h0,    0, 20'h0,     WR_PULSE, 0, 1, 0, 20'hFFFFF, 0, 0, 1, 1, 16'h5A5A, 16'hA5A5));
    vecs.push_back(mk(0, 20'h0,     16'h0,    0, 20'h0,     WR_HOLD,  1, 1, 0, 20'hFFFFF, 1, 0, 1, 1, 16'h5A5A, 16'hA5A5));
    vecs.push_back(mk(0, 20'h0,     16'h0,    0, 20'h0,     IDLE,     1, 1, 1, 20'hFFFFF, 0, 0, 0, 0, 16'h0,    16'hA5A5));
    vecs.push_back(mk(0, 20'h0,     16'h0,    1, 20'hFFFFF, RD_ADDR,  1, 0, 0, 20'hFFFFF, 0, 0, 1, 0, 16'h0,    16'hA5A5));
    vecs.push_back(mk(0, 20'h0,     16'h0,    0, 20'h0,     RD_CAP,   1, 0, 0, 20'hFFFFF, 0, 0, 1, 0, 16'h0,    16'hA5A5));
    vecs.push_back(mk(0, 20'h0,     16'h0,    0, 20'h0,     IDLE,     1, 1, 1, 20'hFFFFF, 0, 1, 0, 0, 16'h0,    16'h5A5A));
    // tie after a read: round-robin gives the write port the bus
    vecs.push_back(mk(1, 20'h00000, 16'h0001, 1, 20'h00010, WR_SETUP, 1, 1, 0, 20'h00000, 0, 0, 1, 1, 16'h0001, 16'h5A5A));
    vecs.push_back(mk(0, 20'h0,     16'h0,    1, 20'h00010, WR_PULSE, 0, 1, 0, 20'h00000, 0, 0, 1, 1, 16'h0001, 16'h5A5A));
    vecs.push_back(mk(0, 20'h0,     16'h0,    1, 20'h00010, WR_HOLD,  1, 1, 0, 20'h00000, 1, 0, 1, 1, 16'h0001, 16'h5A5A));
    vecs.push_back(mk(0, 20'h0,     16'h0,    1, 20'h00010, IDLE,     1, 1, 1, 20'h00000, 0, 0, 0, 0, 16'h0,    16'h5A5A));
    vecs.push_back(mk(0, 20'h0,     16'h0,    1, 20'h00010, RD_ADDR,  1, 0, 0, 20'h00010, 0, 0, 1, 0, 16'h0,    16'h5A5A));
    vecs.push_back(mk(0, 20'h0,     16'h0,    0, 20'h0,     RD_CAP,   1, 0, 0, 20'h00010, 0, 0, 1, 0, 16'h0,    16'h5A5A));
    vecs.push_back(mk(0, 20'h0,     16'h0,    0, 20'h0,     IDLE,     1, 1, 1, 20'h00010, 0, 1, 0, 0, 16'h0,    16'hA5A5));

    // ---------------- reset and idle ----------------
    repeat (3) @(posedge clk);
    #1;
    check("rst_addr", sram0_addr, 20'h0);
    check("rst_rd_data", bus0.o_rd_data, 16'h0);
    @(negedge clk) rst = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("idle_strobes", {we0_n, oe0_n, ce0_n, lb0_n, ub0_n}, 5'b11111);
      check("idle_flags", {bus0.o_busy, bus0.o_wr_ack, bus0.o_rd_valid}, 3'b000);
      check("idle_state", st0, IDLE);
    end

    // ---------------- table-driven write/read sequences ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      bus0.i_wr_req = vecs[i].wr_req; bus0.i_wr_addr = vecs[i].wr_addr;
      bus0.i_wr_data = vecs[i].wr_data;
      bus0.i_rd_req = vecs[i].rd_req; bus0.i_rd_addr = vecs[i].rd_addr;
      @(posedge clk); #1;
      check($sformatf("v%0d_state", i), st0, vecs[i].st);
      check($sformatf("v%0d_strobes", i), {we0_n, oe0_n, ce0_n, lb0_n, ub0_n},
            {vecs[i].we_n, vecs[i].oe_n, vecs[i].ce_n, vecs[i].ce_n, vecs[i].ce_n});
      check($sformatf("v%0d_addr", i), sram0_addr, vecs[i].addr);
      check($sformatf("v%0d_flags", i), {bus0.o_wr_ack, bus0.o_rd_valid, bus0.o_busy},
            {vecs[i].ack, vecs[i].valid, vecs[i].busy});
      check($sformatf("v%0d_rd_data", i), bus0.o_rd_data, vecs[i].rd_data);
      if (vecs[i].dq_chk) check($sformatf("v%0d_dq", i), sram0_dq, vecs[i].dq);
    end

    // ---------------- round-robin with both requests held ----------------
    @(negedge clk) rst = 1;
    @(negedge clk) rst = 0;
    bus0.i_wr_addr = 20'h00020; bus0.i_wr_data = 16'hC3C3;
    bus0.i_rd_addr = 20'h00010;
    bus0.i_wr_req = 1; bus0.i_rd_req = 1;
    gnt_pat = '0; gnt_cnt = 0; ack_cnt = 0; overlap = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if ((st0 == RD_ADDR || st0 == WR_SETUP) && gnt_cnt < 4) begin
        gnt_pat[gnt_cnt] = (st0 == RD_ADDR);
        gnt_cnt++;
      end
      if (bus0.o_wr_ack) ack_cnt++;
      if (bus0.o_rd_valid) ack_cnt++;
      if (!we0_n && !oe0_n) overlap = 1;
    end
    check("rr_grant_count", gnt_cnt, 4);
    check("rr_grant_order", gnt_pat, 4'b0101);
    check("rr_ack_count", ack_cnt, 4);
    check("rr_we_oe_overlap", overlap, 1'b0);
    @(negedge clk);
    bus0.i_wr_req = 0; bus0.i_rd_req = 0;
    repeat (5) @(negedge clk);

    // ---------------- read-first: write starved while read held ----------------
    bus1.i_wr_addr = 20'h00040; bus1.i_wr_data = 16'h7777;
    bus1.i_rd_addr = 20'h00041;
    bus1.i_wr_req = 1; bus1.i_rd_req = 1;
    wr_seen = 0; rv_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (st1 == WR_SETUP || st1 == WR_PULSE || st1 == WR_HOLD || bus1.o_wr_ack) wr_seen = 1;
      if (bus1.o_rd_valid) rv_cnt++;
    end
    check("rf_write_starved", wr_seen, 1'b0);
    check("rf_read_count", rv_cnt, 6);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(posedge clk); #1;
      if (bus1.o_rd_valid) found = 1;
    end
    check("rf_valid_seen", found, 1'b1);
    @(negedge clk) bus1.i_rd_req = 0;
    @(posedge clk); #1;
    check("rf_write_granted", st1, WR_SETUP);
    check("rf_write_addr", sram1_addr, 20'h00040);
    @(negedge clk) bus1.i_wr_req = 0;
    @(posedge clk); #1;
    check("rf_write_pulse", we1_n, 1'b0);
    @(posedge clk); #1;
    check("rf_write_ack", bus1.o_wr_ack, 1'b1);

    // ---------------- reset during WR_PULSE ----------------
    @(negedge clk);
    bus0.i_wr_addr = 20'h00030; bus0.i_wr_data = 16'hBEEF; bus0.i_wr_req = 1;
    @(posedge clk); #1;
    check("rm_setup", st0, WR_SETUP);
    @(negedge clk) bus0.i_wr_req = 0;
    @(posedge clk); #1;
    check("rm_pulse_we", we0_n, 1'b0);
    @(negedge clk) rst = 1;
    @(posedge clk); #1;
    check("rm_strobes", {we0_n, oe0_n, ce0_n, lb0_n, ub0_n}, 5'b11111);
    check("rm_state", st0, IDLE);
    check("rm_flags", {bus0.o_wr_ack, bus0.o_busy}, 2'b00);
    @(negedge clk) rst = 0;
    found = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bus0.o_wr_ack || st0 != IDLE) found = 1;
    end
    check("rm_no_ack", found, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
